// File: rtl/frv_asi_issue.sv
// ASI issue/retire stage: operand hold, result capture, AES flush strobes.
// Define FRV_ASI_ISSUE_STALL_CNT_EN to build the ASI busy-stall counter.
module frv_asi_issue #(
   parameter int UOPW = 7
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [UOPW-1:0] s_uop,
   input  logic [31:0]     s_rs1,
   input  logic [31:0]     s_rs2,
   input  logic [1:0]      s_shamt,
   input  logic [4:0]      s_rd,
   input  logic            kill,
   input  logic            flush_req,
   input  logic [1:0]      flush_sel,
   input  logic [31:0]     flush_data,
   output logic            flush_ack,
   output logic            asi_valid,
   input  logic            asi_ready,
   output logic [UOPW-1:0] asi_uop,
   output logic [31:0]     asi_rs1,
   output logic [31:0]     asi_rs2,
   output logic [1:0]      asi_shamt,
   input  logic [31:0]     asi_result,
   output logic            asi_flush_aessub,
   output logic            asi_flush_aesmix,
   output logic [31:0]     asi_flush_data,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [4:0]      m_rd,
   output logic [31:0]     m_result,
   output logic [15:0]     stall_count,
   input  logic            stall_clr
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      HOLD,
      FLUSH
   } state_t;

   state_t     state;
   logic [1:0] fsel_q;
   logic [4:0] rd_q;
   logic       accept;

   assign asi_valid        = (state == EXEC);
   assign m_valid          = (state == HOLD);
   assign flush_ack        = (state == FLUSH);
   assign asi_flush_aessub = flush_ack & fsel_q[0];
   assign asi_flush_aesmix = flush_ack & fsel_q[1];

   always_comb begin
      s_ready = 1'b0;
      case (state)
         IDLE:    s_ready = !flush_req && !kill;
         HOLD:    s_ready = m_ready && !kill;
         default: s_ready = 1'b0;
      endcase
   end

   assign accept = s_valid && s_ready;

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state          <= IDLE;
         fsel_q         <= '0;
         rd_q           <= '0;
         asi_uop        <= '0;
         asi_rs1        <= '0;
         asi_rs2        <= '0;
         asi_shamt      <= '0;
         asi_flush_data <= '0;
         m_rd           <= '0;
         m_result       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (kill) begin
                  state <= IDLE;
               end else if (flush_req) begin
                  fsel_q         <= flush_sel;
                  asi_flush_data <= flush_data;
                  state          <= FLUSH;
               end else if (accept) begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               // a result arriving with kill is dropped
               if (kill) begin
                  state <= IDLE;
               end else if (asi_ready) begin
                  m_result <= asi_result;
                  m_rd     <= rd_q;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (kill) begin
                  state <= IDLE;
               end else if (m_ready) begin
                  state <= accept ? EXEC : IDLE;
               end
            end
            FLUSH: state <= IDLE;
            default: state <= IDLE;
         endcase
         if (accept) begin
            asi_uop   <= s_uop;
            asi_rs1   <= s_rs1;
            asi_rs2   <= s_rs2;
            asi_shamt <= s_shamt;
            rd_q      <= s_rd;
         end
      end
   end

`ifdef FRV_ASI_ISSUE_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         stall_q <= '0;
      end else if (stall_clr) begin
         stall_q <= '0;
      end else if (asi_valid && !asi_ready && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_count = stall_q;
`else
   logic unused_stall_clr;

   assign unused_stall_clr = stall_clr;
   assign stall_count      = '0;
`endif

endmodule
